// File: rtl/bascomp_pkg.sv
// Shared encodings for the basic-computer control path: bus codes, ALU ops,
// opcodes, register-reference bit positions and the last legal timing step.
package bascomp_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BUS_W  = 3;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned OP_W   = 3;

  // Bus chooser select codes
  localparam logic [BUS_W-1:0] BUS_NONE = 3'd0;
  localparam logic [BUS_W-1:0] BUS_AR   = 3'd1;
  localparam logic [BUS_W-1:0] BUS_PC   = 3'd2;
  localparam logic [BUS_W-1:0] BUS_DR   = 3'd3;
  localparam logic [BUS_W-1:0] BUS_AC   = 3'd4;
  localparam logic [BUS_W-1:0] BUS_IR   = 3'd5;
  localparam logic [BUS_W-1:0] BUS_TR   = 3'd6;
  localparam logic [BUS_W-1:0] BUS_MEM  = 3'd7;

  // AC/ALU operation codes
  localparam logic [ALU_W-1:0] ALU_NONE = 3'd0;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd2;
  localparam logic [ALU_W-1:0] ALU_LDDR = 3'd3;
  localparam logic [ALU_W-1:0] ALU_CLR  = 3'd4;
  localparam logic [ALU_W-1:0] ALU_CMA  = 3'd5;
  localparam logic [ALU_W-1:0] ALU_CIR  = 3'd6;
  localparam logic [ALU_W-1:0] ALU_CIL  = 3'd7;

  // Decoded opcode field IR[14:12]
  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_e;

  // Register-reference bit positions within IR[11:0]
  localparam int unsigned B_CLA = 11;
  localparam int unsigned B_CLE = 10;
  localparam int unsigned B_CMA = 9;
  localparam int unsigned B_CME = 8;
  localparam int unsigned B_CIR = 7;
  localparam int unsigned B_CIL = 6;
  localparam int unsigned B_INC = 5;
  localparam int unsigned B_SPA = 4;
  localparam int unsigned B_SNA = 3;
  localparam int unsigned B_SZA = 2;
  localparam int unsigned B_SZE = 1;
  localparam int unsigned B_HLT = 0;

  // Highest legal timing step (T6)
  localparam int unsigned SC_LAST = 6;

endpackage

// File: rtl/bascomp_control_unit_if.sv
// Control-unit boundary: datapath status in, bus select and strobes out.
interface bascomp_control_unit_if #(
  parameter int unsigned SC_W = 4
);
  import bascomp_pkg::*;

  logic              start;
  logic [WORD_W-1:0] ir_outdata;
  logic [WORD_W-1:0] ac_outdata;
  logic [WORD_W-1:0] dr_outdata;
  logic              e_flag;

  logic [BUS_W-1:0]  buscode;
  logic              ar_ld;
  logic              ar_inr;
  logic              pc_ld;
  logic              pc_inr;
  logic              dr_ld;
  logic              dr_inr;
  logic              ir_ld;
  logic              mem_wr;
  logic [ALU_W-1:0]  alu_op;
  logic              ac_inr;
  logic              e_clr;
  logic              e_cmp;
  logic [SC_W-1:0]   sc;
  logic              running;

  // Control unit side
  modport master (
    input  start, ir_outdata, ac_outdata, dr_outdata, e_flag,
    output buscode, ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr, ir_ld,
           mem_wr, alu_op, ac_inr, e_clr, e_cmp, sc, running
  );

  // Datapath side
  modport slave (
    output start, ir_outdata, ac_outdata, dr_outdata, e_flag,
    input  buscode, ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr, ir_ld,
           mem_wr, alu_op, ac_inr, e_clr, e_cmp, sc, running
  );

endinterface

// File: rtl/bascomp_seq_counter.sv
// Sequence counter SC and run flag S: clear, increment or hold SC while
// running; HLT drops S, start raises it again only while halted.
module bascomp_seq_counter #(
  parameter int unsigned SC_W = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            clr,
  input  logic            inr,
  input  logic            hlt,
  output logic [SC_W-1:0] sc,
  output logic            running
);

  logic [SC_W-1:0] sc_next;
  logic            run_next;

  // Next SC/S; a halted machine only listens to start
  always_comb begin
    sc_next  = sc;
    run_next = running;
    if (running) begin
      if (clr) begin
        sc_next = '0;
      end else if (inr) begin
        sc_next = sc + SC_W'(1);
      end
      if (hlt) begin
        run_next = 1'b0;
      end
    end else if (start) begin
      run_next = 1'b1;
    end
  end

  // State register; reset restarts at T0 in the running state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc      <= '0;
      running <= 1'b1;
    end else begin
      sc      <= sc_next;
      running <= run_next;
    end
  end

endmodule

// File: rtl/bascomp_control_unit.sv
// Timing and control sequencer for the basic computer: fetch, decode,
// indirect and execute of memory- and register-reference instructions.
// Strobes are decoded combinationally from the registered SC/S and inputs.
module bascomp_control_unit
  import bascomp_pkg::*;
#(
  parameter int unsigned SC_W = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  bascomp_control_unit_if.master bus
);

  logic [SC_W-1:0]  sc;
  logic             running;
  logic             sc_clr;
  logic             sc_inr;
  logic             halt_req;

  opcode_e          d;
  logic             ind;
  logic [11:0]      b;
  logic             ac_zero;
  logic             ac_neg;
  logic             ac_op_sel;

  logic [BUS_W-1:0] buscode;
  logic             ar_ld;
  logic             ar_inr;
  logic             pc_ld;
  logic             pc_inr;
  logic             dr_ld;
  logic             dr_inr;
  logic             ir_ld;
  logic             mem_wr;
  logic [ALU_W-1:0] alu_op;
  logic             ac_inr;
  logic             e_clr;
  logic             e_cmp;

  bascomp_seq_counter #(
    .SC_W (SC_W)
  ) u_seq (
    .CLK     (CLK),
    .RST     (RST),
    .start   (bus.start),
    .clr     (sc_clr),
    .inr     (sc_inr),
    .hlt     (halt_req),
    .sc      (sc),
    .running (running)
  );

  // Instruction field decode and AC status
  assign d         = opcode_e'(bus.ir_outdata[14:12]);
  assign ind       = bus.ir_outdata[15];
  assign b         = bus.ir_outdata[11:0];
  assign ac_zero   = (bus.ac_outdata == '0);
  assign ac_neg    = bus.ac_outdata[WORD_W-1];
  assign ac_op_sel = b[B_CLA] | b[B_CMA] | b[B_CIR] | b[B_CIL];

  // Per-step strobe decode; any step not listed (including illegal SC) is idle and clears SC
  always_comb begin
    buscode  = BUS_NONE;
    ar_ld    = 1'b0;
    ar_inr   = 1'b0;
    pc_ld    = 1'b0;
    pc_inr   = 1'b0;
    dr_ld    = 1'b0;
    dr_inr   = 1'b0;
    ir_ld    = 1'b0;
    mem_wr   = 1'b0;
    alu_op   = ALU_NONE;
    ac_inr   = 1'b0;
    e_clr    = 1'b0;
    e_cmp    = 1'b0;
    sc_clr   = 1'b0;
    halt_req = 1'b0;

    if (running) begin
      case (sc)
        SC_W'(0): begin
          buscode = BUS_PC;
          ar_ld   = 1'b1;
        end
        SC_W'(1): begin
          buscode = BUS_MEM;
          ir_ld   = 1'b1;
          pc_inr  = 1'b1;
        end
        SC_W'(2): begin
          buscode = BUS_IR;
          ar_ld   = 1'b1;
        end
        SC_W'(3): begin
          if (d != OP_REG) begin
            if (ind) begin
              buscode = BUS_MEM;
              ar_ld   = 1'b1;
            end
          end else if (ind) begin
            sc_clr = 1'b1;
          end else begin
            sc_clr = 1'b1;
            if (b[B_CLA]) begin
              alu_op = ALU_CLR;
            end else if (b[B_CMA]) begin
              alu_op = ALU_CMA;
            end else if (b[B_CIR]) begin
              alu_op = ALU_CIR;
            end else if (b[B_CIL]) begin
              alu_op = ALU_CIL;
            end
            ac_inr   = b[B_INC] & ~ac_op_sel;
            e_clr    = b[B_CLE];
            e_cmp    = b[B_CME] & ~b[B_CLE];
            pc_inr   = (b[B_SPA] & ~ac_neg) | (b[B_SNA] & ac_neg) |
                       (b[B_SZA] & ac_zero) | (b[B_SZE] & ~bus.e_flag);
            halt_req = b[B_HLT];
          end
        end
        SC_W'(4): begin
          case (d)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              buscode = BUS_MEM;
              dr_ld   = 1'b1;
            end
            OP_STA: begin
              buscode = BUS_AC;
              mem_wr  = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BUN: begin
              buscode = BUS_AR;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BSA: begin
              buscode = BUS_PC;
              mem_wr  = 1'b1;
              ar_inr  = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        SC_W'(5): begin
          sc_clr = 1'b1;
          case (d)
            OP_AND: alu_op = ALU_AND;
            OP_ADD: alu_op = ALU_ADD;
            OP_LDA: alu_op = ALU_LDDR;
            OP_BSA: begin
              buscode = BUS_AR;
              pc_ld   = 1'b1;
            end
            OP_ISZ: begin
              dr_inr = 1'b1;
              sc_clr = 1'b0;
            end
            default: ;
          endcase
        end
        SC_W'(SC_LAST): begin
          sc_clr = 1'b1;
          if (d == OP_ISZ) begin
            buscode = BUS_DR;
            mem_wr  = 1'b1;
            pc_inr  = (bus.dr_outdata == '0);
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end

    sc_inr = ~sc_clr;
  end

  // Drive the interface
  assign bus.buscode = buscode;
  assign bus.ar_ld   = ar_ld;
  assign bus.ar_inr  = ar_inr;
  assign bus.pc_ld   = pc_ld;
  assign bus.pc_inr  = pc_inr;
  assign bus.dr_ld   = dr_ld;
  assign bus.dr_inr  = dr_inr;
  assign bus.ir_ld   = ir_ld;
  assign bus.mem_wr  = mem_wr;
  assign bus.alu_op  = alu_op;
  assign bus.ac_inr  = ac_inr;
  assign bus.e_clr   = e_clr;
  assign bus.e_cmp   = e_cmp;
  assign bus.sc      = sc;
  assign bus.running = running;

endmodule

// File: tb/tb_bascomp_control_unit.sv
// Bench for bascomp_control_unit: per-instruction expected micro-step traces
// built from the instruction tables, compared cycle by cycle.
module tb_bascomp_control_unit;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  bascomp_control_unit_if #(.SC_W(4)) bus_if ();

  bascomp_control_unit #(.SC_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  // Strobe bit positions inside the packed expectation word
  localparam int unsigned AR_LD  = 1 << 10;
  localparam int unsigned AR_INR = 1 << 9;
  localparam int unsigned PC_LD  = 1 << 8;
  localparam int unsigned PC_INR = 1 << 7;
  localparam int unsigned DR_LD  = 1 << 6;
  localparam int unsigned DR_INR = 1 << 5;
  localparam int unsigned IR_LD  = 1 << 4;
  localparam int unsigned MEM_WR = 1 << 3;
  localparam int unsigned AC_INR = 1 << 2;
  localparam int unsigned E_CLR  = 1 << 1;
  localparam int unsigned E_CMP  = 1 << 0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];
  bit          last_halt;

  function automatic logic [16:0] st(input logic [2:0] bc, input logic [2:0] alu,
                                     input int unsigned stb);
    logic [10:0] s;
    s = stb[10:0];
    return {bc, alu, s};
  endfunction

  function automatic logic [16:0] obs();
    return {bus_if.buscode, bus_if.alu_op, bus_if.ar_ld, bus_if.ar_inr, bus_if.pc_ld,
            bus_if.pc_inr, bus_if.dr_ld, bus_if.dr_inr, bus_if.ir_ld, bus_if.mem_wr,
            bus_if.ac_inr, bus_if.e_clr, bus_if.e_cmp};
  endfunction

  // Reference: expected control word for each timing step of one instruction
  task automatic build_trace(input logic [15:0] ir, input logic [15:0] ac,
                             input logic [15:0] dr6, input logic e, output bit halts);
    logic [2:0]  d;
    logic [11:0] b;
    logic [2:0]  alu;
    int unsigned s;
    exp_q.delete();
    halts = 1'b0;
    d = ir[14:12];
    b = ir[11:0];
    exp_q.push_back(st(3'd2, 3'd0, AR_LD));
    exp_q.push_back(st(3'd7, 3'd0, IR_LD | PC_INR));
    exp_q.push_back(st(3'd5, 3'd0, AR_LD));
    if (d == 3'd7) begin
      if (ir[15]) begin
        exp_q.push_back(st(3'd0, 3'd0, 0));
      end else begin
        s = 0;
        if (b[11])      alu = 3'd4;
        else if (b[9])  alu = 3'd5;
        else if (b[7])  alu = 3'd6;
        else if (b[6])  alu = 3'd7;
        else            alu = 3'd0;
        if (b[5] && alu == 3'd0) s |= AC_INR;
        if (b[10]) s |= E_CLR;
        if (b[8] && !b[10]) s |= E_CMP;
        if ((b[4] && ac < 16'h8000) || (b[3] && ac >= 16'h8000) ||
            (b[2] && ac == 16'h0000) || (b[1] && !e)) s |= PC_INR;
        exp_q.push_back(st(3'd0, alu, s));
        halts = b[0];
      end
    end else begin
      exp_q.push_back(ir[15] ? st(3'd7, 3'd0, AR_LD) : st(3'd0, 3'd0, 0));
      case (d)
        3'd0, 3'd1, 3'd2: begin
          exp_q.push_back(st(3'd7, 3'd0, DR_LD));
          exp_q.push_back(st(3'd0, d + 3'd1, 0));
        end
        3'd3: exp_q.push_back(st(3'd4, 3'd0, MEM_WR));
        3'd4: exp_q.push_back(st(3'd1, 3'd0, PC_LD));
        3'd5: begin
          exp_q.push_back(st(3'd2, 3'd0, MEM_WR | AR_INR));
          exp_q.push_back(st(3'd1, 3'd0, PC_LD));
        end
        default: begin
          exp_q.push_back(st(3'd7, 3'd0, DR_LD));
          exp_q.push_back(st(3'd0, 3'd0, DR_INR));
          exp_q.push_back(st(3'd3, 3'd0, MEM_WR | ((dr6 == 16'h0) ? PC_INR : 0)));
        end
      endcase
    end
  endtask

  // Runs one instruction from T0; starts and ends just after a rising edge
  task automatic run_instr(input string name, input logic [15:0] ir, input logic [15:0] ac,
                           input logic [15:0] dr, input logic [15:0] dr6, input logic e);
    bit halts;
    build_trace(ir, ac, dr6, e, halts);
    bus_if.ir_outdata = ir;
    bus_if.ac_outdata = ac;
    bus_if.dr_outdata = dr;
    bus_if.e_flag     = e;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == 6) bus_if.dr_outdata = dr6;
      @(negedge CLK);
      n_checks++;
      if ({obs(), bus_if.sc, bus_if.running} !== {exp_q[k], 4'(k), 1'b1}) begin
        n_fail++;
        $display("FAIL %s T%0d: got ctl=%h sc=%0d running=%b, want ctl=%h sc=%0d running=1",
                 name, k, obs(), bus_if.sc, bus_if.running, exp_q[k], k);
      end
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (bus_if.sc !== 4'd0 || bus_if.running !== ~halts) begin
      n_fail++;
      $display("FAIL %s end: got sc=%0d running=%b, want sc=0 running=%b",
               name, bus_if.sc, bus_if.running, ~halts);
    end
    last_halt = halts;
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    @(posedge CLK);
    #1;
    bus_if.start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.ir_outdata = 16'h1234;
    bus_if.ac_outdata = 16'h0;
    bus_if.dr_outdata = 16'h0;
    bus_if.e_flag     = 1'b0;
    #2;
    n_checks++;
    if ({obs(), bus_if.sc, bus_if.running} !== {st(3'd2, 3'd0, AR_LD), 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: got ctl=%h sc=%0d running=%b, want ctl=%h sc=0 running=1",
               obs(), bus_if.sc, bus_if.running, st(3'd2, 3'd0, AR_LD));
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_if.ir_outdata = 16'h1050;
    repeat (4) begin
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    n_checks++;
    if (bus_if.sc !== 4'd4 || bus_if.buscode !== 3'd7 || bus_if.dr_ld !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got sc=%0d bus=%0d dr_ld=%b, want sc=4 bus=7 dr_ld=1",
               bus_if.sc, bus_if.buscode, bus_if.dr_ld);
    end
    #1 RST = 1'b1;
    #1;
    n_checks++;
    if ({obs(), bus_if.sc, bus_if.running} !== {st(3'd2, 3'd0, AR_LD), 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid: got ctl=%h sc=%0d running=%b, want ctl=%h sc=0 running=1",
               obs(), bus_if.sc, bus_if.running, st(3'd2, 3'd0, AR_LD));
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    run_instr("add_after_reset", 16'h1050, 16'h0001, 16'h0002, 16'h0002, 1'b0);
  endtask

  task automatic test_mem_ref();
    run_instr("lda_direct", 16'h2123, 16'h0, 16'h0, 16'h0, 1'b0);
    run_instr("add_indirect", 16'h9050, 16'h1, 16'h2, 16'h2, 1'b1);
    run_instr("and", 16'h0777, 16'h5, 16'h3, 16'h3, 1'b0);
    run_instr("sta", 16'h3010, 16'h5, 16'h3, 16'h3, 1'b0);
    run_instr("bun_indirect", 16'hC020, 16'h5, 16'h3, 16'h3, 1'b0);
    run_instr("bsa", 16'h5100, 16'h5, 16'h3, 16'h3, 1'b0);
  endtask

  task automatic test_isz();
    run_instr("isz_zero", 16'h6200, 16'h0, 16'h0, 16'h0000, 1'b0);
    run_instr("isz_nonzero", 16'h6200, 16'h0, 16'h0, 16'h0005, 1'b0);
    run_instr("isz_wrap", 16'hE200, 16'h0, 16'hFFFF, 16'h0000, 1'b0);
  endtask

  task automatic test_reg_ref();
    run_instr("cla_cma", 16'h7A00, 16'h1234, 16'h0, 16'h0, 1'b0);
    run_instr("sza_zero", 16'h7004, 16'h0000, 16'h0, 16'h0, 1'b0);
    run_instr("sza_nonzero", 16'h7004, 16'h0010, 16'h0, 16'h0, 1'b0);
    run_instr("cle_cme", 16'h7500, 16'h0, 16'h0, 16'h0, 1'b1);
    run_instr("inc_cir", 16'h70A0, 16'h0, 16'h0, 16'h0, 1'b1);
    run_instr("inc_only", 16'h7020, 16'h8000, 16'h0, 16'h0, 1'b0);
    run_instr("sna_sze", 16'h700A, 16'h8000, 16'h0, 16'h0, 1'b1);
    run_instr("nop", 16'h7000, 16'h0, 16'h0, 16'h0, 1'b0);
    run_instr("io_nop", 16'hF7FF, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_halt();
    run_instr("hlt", 16'h7001, 16'h0, 16'h0, 16'h0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      bus_if.ir_outdata = 16'($urandom);
      bus_if.ac_outdata = 16'($urandom);
      bus_if.dr_outdata = 16'h0;
      @(negedge CLK);
      n_checks++;
      if ({obs(), bus_if.sc, bus_if.running} !== {17'h0, 4'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL halted_c%0d: got ctl=%h sc=%0d running=%b, want ctl=0 sc=0 running=0",
                 c, obs(), bus_if.sc, bus_if.running);
      end
      @(posedge CLK);
      #1;
    end
    pulse_start();
    run_instr("fetch_after_start", 16'h4010, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_start_hlt_same();
    bus_if.start = 1'b1;
    run_instr("hlt_with_start", 16'h7001, 16'h0, 16'h0, 16'h0, 1'b0);
    bus_if.start = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bus_if.running !== 1'b0 || obs() !== 17'h0) begin
      n_fail++;
      $display("FAIL hlt_start_hold: got running=%b ctl=%h, want running=0 ctl=0",
               bus_if.running, obs());
    end
    @(posedge CLK);
    #1;
    pulse_start();
    run_instr("resume", 16'h2123, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_start_while_running();
    bus_if.start = 1'b1;
    run_instr("start_running", 16'h1050, 16'h0, 16'h0, 16'h0, 1'b0);
    bus_if.start = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] ir, ac, dr, dr6;
    for (int n = 0; n < 200; n++) begin
      ir  = 16'($urandom);
      ac  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      dr  = 16'($urandom);
      dr6 = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      run_instr("random", ir, ac, dr, dr6, 1'($urandom_range(0, 1)));
      if (last_halt) pulse_start();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mem_ref();
    test_isz();
    test_reg_ref();
    test_halt();
    test_start_hlt_same();
    test_start_while_running();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
